mem_stage_ws: RTL
=================

// Module: mem_stage_ws
// PURPOSE
//  Parametrised MEM stage for the ARM pipeline. Holds the data memory with a configurable number of
//  wait states and the MEM/WB pipeline register. Raises freeze to stall upstream stages while an
//  access is outstanding, and injects bubbles into WB during the stall.
//  With WAIT_CYCLES=0 it is a single-cycle MEM stage plus MEM/WB register.
// PARAMETERS
//  DATA_W       32  data/address width in bits
//  DEPTH        64  data memory size in DATA_W words; power of two; AW=$clog2(DEPTH)
//  WAIT_CYCLES  2   extra cycles per load/store (0..15); access occupies WAIT_CYCLES+1 cycles
//  DEST_W       4   destination register index width
// PORTS
//  clk             in   1       clock; all state on rising edge
//  rst             in   1       asynchronous, active-high reset
//  WB_en_in        in   1       writeback enable from EXE/MEM
//  MEM_R_en_in     in   1       load request
//  MEM_W_en_in     in   1       store request
//  ALU_result_in   in   DATA_W  byte address (loads/stores) or ALU result
//  Val_Rm_in       in   DATA_W  store data
//  Dest_in         in   DEST_W  destination register
//  freeze          out  1       stall upstream; combinational
//  WB_en           out  1       registered to WB
//  MEM_R_en        out  1       registered to WB
//  ALU_result      out  DATA_W  registered to WB
//  Mem_read_value  out  DATA_W  registered load data
//  Dest            out  DEST_W  registered to WB
// BEHAVIOUR
//  - Word index = ALU_result_in[AW+1:2]. Bits [1:0] are ignored (no misalign trap).
//    Bits above AW+1 are ignored, so addresses alias modulo DEPTH words.
//  - Memory array is not reset. Contents are X until written.
//  - op = MEM_R_en_in | MEM_W_en_in.
//    Wait counter cnt (4 bit): IDLE when cnt==0, WAIT otherwise.
//  - freeze = op && (cnt != WAIT_CYCLES). Upstream holds all *_in stable while freeze=1.
//  - Each edge with op && cnt!=WAIT_CYCLES: cnt<=cnt+1, no memory side effect.
//  - Edge with op && cnt==WAIT_CYCLES (completion):
//    - cnt<=0.
//    - If store: mem[idx]<=Val_Rm_in.
//    - Output register loads {WB_en_in, MEM_R_en_in, ALU_result_in, mem[idx] (pre-write value), Dest_in}.
//  - Edge with !op: cnt<=0; output register loads inputs directly, with Mem_read_value<=mem[idx].
//  - While freeze=1, each edge loads a bubble: WB_en<=0, MEM_R_en<=0.
//    ALU_result, Mem_read_value and Dest hold their values.
//  - Latency: non-memory op, 1 cycle. Load/store, WAIT_CYCLES+1 cycles from first presentation
//    to output register update.
//  - Both R and W enabled together: treated as store; Mem_read_value returns the old word.
//  - Back-to-back store then load to the same word: the load returns the stored data.
//    The store commits at its completion edge, before the load begins.
//  - op dropping while cnt>0 (illegal upstream behaviour): cnt<=0, access abandoned, no write.
//  - Reset (async, any time) clears cnt and all outputs to 0.
//    A store whose completion edge coincides with rst high is not committed.
// TESTING
//  - Reset mid-access: WAIT_CYCLES=2, store 0xDEADBEEF to 0x40, assert rst at cnt=1.
//    -> outputs 0, freeze=0 after release; a later load of 0x40 does not return 0xDEADBEEF.
//  - Store/load latency: WAIT_CYCLES=2, store 0x12345678 to 0x10.
//    -> freeze=1 for 2 cycles, WB_en=0 bubbles during the stall.
//    Then load 0x10 with Dest=5. -> 3rd edge: Mem_read_value=0x12345678, MEM_R_en=1, WB_en=1, Dest=5.
//  - Zero wait: WAIT_CYCLES=0, ALU op ALU_result_in=7, WB_en_in=1, Dest_in=3.
//    -> freeze never asserted; next edge ALU_result=7, WB_en=1, Dest=3.
//  - Aliasing: DEPTH=64, store 0xA5 to 0x004, load 0x104.
//    -> Mem_read_value=0xA5; load from 0x006 also returns 0xA5.
//  - Simultaneous R/W: mem[2]=0x11; assert R and W to 0x8 with data 0x22.
//    -> Mem_read_value=0x11; a subsequent load returns 0x22.
//  - Bubble hold: during freeze, WB_en=0 and MEM_R_en=0; ALU_result and Dest unchanged
//    from the previous instruction.

Source files
------------

// File: rtl/mem_stage_ws.sv
// MEM stage with a wait-stated data memory and MEM/WB register; freezes upstream
// while a load/store is outstanding and feeds bubbles into WB meanwhile.
//   state | meaning
//   IDLE  | cnt_q == 0, no access in progress (or a zero-wait access completing)
//   WAIT  | cnt_q != 0, access counting towards WAIT_CYCLES
module mem_stage_ws #(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 2,
    parameter int DEST_W      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              WB_en_in,
    input  logic              MEM_R_en_in,
    input  logic              MEM_W_en_in,
    input  logic [DATA_W-1:0] ALU_result_in,
    input  logic [DATA_W-1:0] Val_Rm_in,
    input  logic [DEST_W-1:0] Dest_in,
    output logic              freeze,
    output logic              WB_en,
    output logic              MEM_R_en,
    output logic [DATA_W-1:0] ALU_result,
    output logic [DATA_W-1:0] Mem_read_value,
    output logic [DEST_W-1:0] Dest
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] WC = 4'(WAIT_CYCLES);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [3:0]        cnt_q, cnt_d;
    logic              op;
    logic              done;
    logic [AW-1:0]     idx;

    logic              wb_en_q, mem_r_en_q;
    logic [DATA_W-1:0] alu_result_q, mem_read_value_q;
    logic [DEST_W-1:0] dest_q;

    assign op  = MEM_R_en_in | MEM_W_en_in;
    assign idx = ALU_result_in[AW+1:2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= 4'd0;
        else     cnt_q <= cnt_d;
    end

    // Dropping op mid-access abandons it; the counter simply restarts.
    always_comb begin
        cnt_d = 4'd0;
        if (op && (cnt_q != WC)) cnt_d = cnt_q + 4'd1;
    end

    always_comb begin
        freeze = op && (cnt_q != WC);
        done   = op && (cnt_q == WC);
    end

    // Array is deliberately unreset; a completion edge under reset must not commit.
    always_ff @(posedge clk) begin
        if (done && MEM_W_en_in && !rst) mem_q[idx] <= Val_Rm_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_en_q          <= 1'b0;
            mem_r_en_q       <= 1'b0;
            alu_result_q     <= '0;
            mem_read_value_q <= '0;
            dest_q           <= '0;
        end else if (freeze) begin
            wb_en_q    <= 1'b0;
            mem_r_en_q <= 1'b0;
        end else begin
            wb_en_q          <= WB_en_in;
            mem_r_en_q       <= MEM_R_en_in;
            alu_result_q     <= ALU_result_in;
            mem_read_value_q <= mem_q[idx];
            dest_q           <= Dest_in;
        end
    end

    assign WB_en          = wb_en_q;
    assign MEM_R_en       = mem_r_en_q;
    assign ALU_result     = alu_result_q;
    assign Mem_read_value = mem_read_value_q;
    assign Dest           = dest_q;

endmodule
